// File: rtl/change_dispenser.sv
// Greedy 25/10/5 change payout with hopper strobes and recovery gaps.
// Optional hopper inventory: define CHANGE_INVENTORY_EN.
module change_dispenser #(
  parameter int AMOUNT_W   = 8,
  parameter int GAP_CYCLES = 1,
  parameter int INV_W      = 6,
  parameter int INIT_COUNT = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                changeValid,
  input  logic [AMOUNT_W-1:0] changeAmount,
  output logic                changeReady,
  output logic                fiveRupeesOut,
  output logic                tenRupeesOut,
  output logic                twentyFiveRupeesOut,
  output logic                changeDone,
  output logic                changeError,
  output logic [AMOUNT_W-1:0] residue,
  input  logic                refill,
  output logic [2:0]          coinsEmpty
);

  typedef enum logic [1:0] {IDLE, PAY, GAP} state_t;

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [INV_W-1:0] INIT_V = INV_W'(INIT_COUNT);
  localparam logic [AMOUNT_W-1:0] C5  = AMOUNT_W'(5);
  localparam logic [AMOUNT_W-1:0] C10 = AMOUNT_W'(10);
  localparam logic [AMOUNT_W-1:0] C25 = AMOUNT_W'(25);

  state_t              state;
  state_t              nstate;
  logic [AMOUNT_W-1:0] remaining;
  logic [GW-1:0]       gap_cnt;
  logic [2:0]          avail;
  logic [2:0]          pick;
  logic [AMOUNT_W-1:0] coin;
  logic                bad;
  logic                accept;
  logic                ready_d;
  logic [2:0]          strobe_d;
  logic                done_d;
  logic                err_d;

  assign accept = changeValid && changeReady;
  assign bad    = (remaining % C5) != '0;

  // Greedy coin choice: largest in-stock coin not exceeding remaining
  always_comb begin
    pick = 3'b000;
    coin = '0;
    if (state == PAY && !bad) begin
      if (remaining >= C25 && avail[2]) begin
        pick = 3'b100;
        coin = C25;
      end else if (remaining >= C10 && avail[1]) begin
        pick = 3'b010;
        coin = C10;
      end else if (remaining >= C5 && avail[0]) begin
        pick = 3'b001;
        coin = C5;
      end
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (accept) nstate = PAY;
      PAY:     nstate = (pick != 3'b000) ? GAP : IDLE;
      GAP:     if (gap_cnt == '0) nstate = PAY;
      default: nstate = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    ready_d  = 1'b0;
    strobe_d = 3'b000;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state)
      IDLE: ready_d = !accept;
      PAY: begin
        strobe_d = pick;
        done_d   = (remaining == '0);
        err_d    = (remaining != '0) && (pick == 3'b000);
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      changeReady         <= 1'b1;
      twentyFiveRupeesOut <= 1'b0;
      tenRupeesOut        <= 1'b0;
      fiveRupeesOut       <= 1'b0;
      changeDone          <= 1'b0;
      changeError         <= 1'b0;
    end else begin
      changeReady         <= ready_d;
      twentyFiveRupeesOut <= strobe_d[2];
      tenRupeesOut        <= strobe_d[1];
      fiveRupeesOut       <= strobe_d[0];
      changeDone          <= done_d;
      changeError         <= err_d;
    end
  end

  // Amount bookkeeping, gap timer and residue capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
      gap_cnt   <= '0;
      residue   <= '0;
    end else begin
      if (accept) begin
        remaining <= changeAmount;
        residue   <= '0;
      end else if (pick != 3'b000) begin
        remaining <= remaining - coin;
        gap_cnt   <= GW'(GAP_CYCLES - 1);
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      if (err_d) residue <= remaining;
    end
  end

`ifdef CHANGE_INVENTORY_EN
  logic [INV_W-1:0] cnt25;
  logic [INV_W-1:0] cnt10;
  logic [INV_W-1:0] cnt5;

  assign avail      = {cnt25 != '0, cnt10 != '0, cnt5 != '0};
  assign coinsEmpty = ~avail;

  // Hopper counters; refill beats a same-cycle ejection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt25 <= INIT_V;
      cnt10 <= INIT_V;
      cnt5  <= INIT_V;
    end else if (refill) begin
      cnt25 <= INIT_V;
      cnt10 <= INIT_V;
      cnt5  <= INIT_V;
    end else begin
      if (pick[2]) cnt25 <= cnt25 - 1'b1;
      if (pick[1]) cnt10 <= cnt10 - 1'b1;
      if (pick[0]) cnt5  <= cnt5 - 1'b1;
    end
  end
`else
  logic unused_sink;

  assign avail       = 3'b111;
  assign coinsEmpty  = 3'b000;
  assign unused_sink = ^{refill, INIT_V};
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser (GAP_CYCLES=1, INIT_COUNT=10).
// Inventory checks are built only with CHANGE_INVENTORY_EN.
module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       changeValid = 1'b0;
  logic [7:0] changeAmount = '0;
  logic       refill = 1'b0;
  logic       changeReady;
  logic       fiveRupeesOut;
  logic       tenRupeesOut;
  logic       twentyFiveRupeesOut;
  logic       changeDone;
  logic       changeError;
  logic [7:0] residue;
  logic [2:0] coinsEmpty;

  int vecs = 0;
  int errs = 0;
  logic [5:0] eq[$];

  change_dispenser #(
    .AMOUNT_W(8),
    .GAP_CYCLES(1),
    .INV_W(6),
    .INIT_COUNT(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .changeValid(changeValid),
    .changeAmount(changeAmount),
    .changeReady(changeReady),
    .fiveRupeesOut(fiveRupeesOut),
    .tenRupeesOut(tenRupeesOut),
    .twentyFiveRupeesOut(twentyFiveRupeesOut),
    .changeDone(changeDone),
    .changeError(changeError),
    .residue(residue),
    .refill(refill),
    .coinsEmpty(coinsEmpty)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // octal code: 4x=ready 2x=done 1x=error, x4=25 x2=10 x1=5
  function automatic logic [5:0] code();
    return {changeReady, changeDone, changeError,
            twentyFiveRupeesOut, tenRupeesOut, fiveRupeesOut};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input string tag, input logic [7:0] amt,
                     input bit hold, input bit rf);
    for (int i = 0; i < 20 && changeReady !== 1'b1; i++) step();
    chk({tag, " ready"}, 32'(changeReady), 32'd1);
    changeValid  = 1'b1;
    changeAmount = amt;
    step();
    if (!hold) changeValid = 1'b0;
    refill = rf;
    chk({tag, " c0"}, 32'(code()), 32'o00);
    chk({tag, " residue clr"}, 32'(residue), 32'd0);
    foreach (eq[i]) begin
      step();
      refill = 1'b0;
      chk($sformatf("%s c%0d", tag, i + 1), 32'(code()), 32'(eq[i]));
    end
    changeValid = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst code", 32'(code()), 32'o40);
    chk("rst residue", 32'(residue), 32'd0);
    chk("rst empty", 32'(coinsEmpty), 32'd0);
    reset = 1'b1;
    step();
    chk("rel code", 32'(code()), 32'o40);

    eq = '{6'o04, 6'o00, 6'o02, 6'o00, 6'o01, 6'o00, 6'o20, 6'o40};
    run("a40", 8'd40, 1'b0, 1'b0);
    chk("a40 residue", 32'(residue), 32'd0);

    eq = '{6'o20, 6'o40};
    run("a0", 8'd0, 1'b0, 1'b0);

    eq = '{6'o10, 6'o40};
    run("a23", 8'd23, 1'b0, 1'b0);
    chk("a23 residue", 32'(residue), 32'd23);

    eq = '{6'o02, 6'o00, 6'o02, 6'o00, 6'o20, 6'o40};
    run("a20", 8'd20, 1'b0, 1'b0);

    eq = '{6'o02, 6'o00, 6'o01, 6'o00, 6'o20, 6'o40,
           6'o00, 6'o02, 6'o00, 6'o01, 6'o00, 6'o20, 6'o40};
    run("hold15", 8'd15, 1'b1, 1'b0);
    step();
    chk("hold idle1", 32'(code()), 32'o40);
    step();
    chk("hold idle2", 32'(code()), 32'o40);

    eq = '{6'o04, 6'o00, 6'o04, 6'o00, 6'o01, 6'o00, 6'o20, 6'o40};
    run("a55", 8'd55, 1'b0, 1'b0);

    eq = '{6'o04};
    run("r75", 8'd75, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("r75 abort code", 32'(code()), 32'o40);
    chk("r75 abort residue", 32'(residue), 32'd0);
    chk("r75 abort empty", 32'(coinsEmpty), 32'd0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("r75 quiet%0d", i), 32'(code()), 32'o40);
    end

`ifdef CHANGE_INVENTORY_EN
    eq = '{6'o02, 6'o00, 6'o20, 6'o40};
    for (int i = 0; i < 10; i++) run("drain10", 8'd10, 1'b0, 1'b0);
    chk("empty10", 32'(coinsEmpty), 32'b010);

    eq = '{6'o01, 6'o00, 6'o01, 6'o00, 6'o01, 6'o00,
           6'o01, 6'o00, 6'o20, 6'o40};
    run("i20", 8'd20, 1'b0, 1'b0);
    chk("i20 empty", 32'(coinsEmpty), 32'b010);

    eq = '{6'o01, 6'o00, 6'o20, 6'o40};
    for (int i = 0; i < 6; i++) run("drain5", 8'd5, 1'b0, 1'b0);
    chk("empty5", 32'(coinsEmpty), 32'b011);

    eq = '{6'o04, 6'o00, 6'o10, 6'o40};
    run("i30", 8'd30, 1'b0, 1'b0);
    chk("i30 residue", 32'(residue), 32'd5);

    eq = '{6'o04, 6'o00, 6'o20, 6'o40};
    for (int i = 0; i < 9; i++) run("drain25", 8'd25, 1'b0, 1'b0);
    chk("empty25", 32'(coinsEmpty), 32'b111);

    eq = '{6'o10, 6'o40};
    run("i25 dry", 8'd25, 1'b0, 1'b0);
    chk("i25 dry residue", 32'(residue), 32'd25);

    refill = 1'b1;
    step();
    refill = 1'b0;
    chk("refill empty", 32'(coinsEmpty), 32'b000);

    eq = '{6'o04, 6'o00, 6'o20, 6'o40};
    run("rf25", 8'd25, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) run("post25", 8'd25, 1'b0, 1'b0);
    chk("rf prio", 32'(coinsEmpty[2]), 32'd0);
    run("last25", 8'd25, 1'b0, 1'b0);
    chk("rf drained", 32'(coinsEmpty[2]), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out change as discrete coin pulses after a sale in the vending machine. The sale FSM computes the overpaid amount and hands it over with a valid/ready handshake. This block breaks the amount into 25/10/5-rupee coins using a strict greedy rule. It drives one hopper strobe per coin with a recovery gap between coins, then reports done or error.

## Interface
- AMOUNT_W, 8: width of change amount in rupees
- GAP_CYCLES, 1: idle cycles (≥1) after every coin pulse for hopper recovery
- INV_W, 6: width of each per-denomination coin counter
- INIT_COUNT, 10: coins per denomination after reset/refill (must fit INV_W)

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- changeValid  input  1  change request present
- changeAmount  input  AMOUNT_W  change to pay, rupees; sampled on accept
- changeReady  output  1  block idle, can accept a request
- fiveRupeesOut  output  1  one-cycle strobe: eject one 5-rupee coin
- tenRupeesOut  output  1  one-cycle strobe: eject one 10-rupee coin
- twentyFiveRupeesOut  output  1  one-cycle strobe: eject one 25-rupee coin
- changeDone  output  1  one-cycle pulse: full amount paid
- changeError  output  1  one-cycle pulse: request aborted
- residue  output  AMOUNT_W  unpaid amount of last request; held until next accept
- refill  input  1  reload all hoppers to INIT_COUNT (inventory build only)
- coinsEmpty  output  3  {25,10,5} hopper counter is zero (inventory build only)

## Operation
- States: IDLE, PAY, GAP. changeReady=1 only in IDLE.
- Accept: changeValid && changeReady at a rising edge. This latches remaining=changeAmount, clears residue and enters PAY.
- If changeAmount % 5 != 0 at accept, no coins are paid. changeError pulses in the first PAY slot, residue=changeAmount, then IDLE.
- PAY slot, evaluated each time PAY is entered:
  - remaining==0: changeDone pulses, then IDLE.
  - Otherwise pick the largest coin ≤ remaining that is in stock. Strict greedy, no backtracking. Assert its strobe for this cycle, subtract its value, decrement its counter, enter GAP.
  - No eligible coin: changeError pulses, residue=remaining, then IDLE. Coins already ejected are not recalled.
- GAP lasts exactly GAP_CYCLES cycles with all strobes low, then PAY.
- At most one coin strobe is high in any cycle. Strobes never coincide with changeDone/changeError.
- All outputs are registered. changeValid is ignored outside IDLE.
- Arithmetic: remaining is AMOUNT_W bits. Subtraction is only ever of a coin ≤ remaining, so it never underflows.

## Timing
- Reset (async assert, sync release) forces:
  - IDLE, changeReady=1, all strobes 0, changeDone=0, changeError=0, residue=0.
  - Counters set to INIT_COUNT.
- Reset mid-payout aborts immediately. Strobes drop with no further coins.
- Accept at edge k: first PAY slot output is high during cycle k+1.
- Each coin costs 1+GAP_CYCLES cycles. changeDone/changeError occupy the slot after the last gap. changeReady returns the cycle after that pulse.
- Example, amount 40, GAP_CYCLES=1: 25 at k+1, 10 at k+3, 5 at k+5, changeDone at k+7, changeReady at k+8.
- Amount 0: changeDone at k+1, no strobes.

## Configuration
- CHANGE_INVENTORY_EN defined:
  - Per-denomination INV_W counters are tracked. A coin with counter 0 is not eligible.
  - coinsEmpty reflects counters.
  - refill high at an edge reloads all counters to INIT_COUNT. Refill takes priority over a same-cycle decrement.
- Undefined:
  - Hoppers are treated as unlimited and no counters are built.
  - refill is ignored and coinsEmpty is tied to 0.
  - changeError occurs only for non-multiple-of-5 amounts.

## Test plan
- Reset, then amount 40, GAP_CYCLES=1: strobes 25@k+1, 10@k+3, 5@k+5, changeDone@k+7, residue=0, changeReady@k+8.
- Amount 0: changeDone@k+1, no strobes. Amount 23: changeError@k+1, residue=23, no strobes.
- Inventory build, 10-rupee hopper emptied, amount 20: four 5-rupee strobes, then changeDone. Amount 30 with 5-rupee hopper empty: one 25 strobe, then changeError with residue=5 (greedy, no backtrack).
- changeValid held high during a payout: no second accept until changeReady returns. Back-to-back requests are each paid exactly.
- Assert reset mid-payout of 75 after the first 25 strobe: all outputs go to reset values immediately and no further strobes occur. After release, counters are INIT_COUNT.
- Inventory build: drain the 25-rupee hopper to 0, coinsEmpty[2]=1. Then pulse refill in the same cycle as a 25 strobe: counter=INIT_COUNT and coinsEmpty[2]=0.
